// File: rtl/bus_arbiter_rr_if.sv
// Shared-bus arbitration interface: requests, slave events, and grant/status back.
interface bus_arbiter_rr_if #(
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned ID_W      = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
);
  logic [N_MASTERS-1:0] m_req;
  logic [N_MASTERS-1:0] m_grant;
  logic [N_MASTERS-1:0] m_timeout;
  logic                 bus_done;
  logic                 bus_split;
  logic [N_MASTERS-1:0] split_release;
  logic [ID_W-1:0]      owner_id;
  logic                 bus_busy;
  logic [1:0]           arb_state;

  modport master (
    output m_req, bus_done, bus_split, split_release,
    input  m_grant, m_timeout, owner_id, bus_busy, arb_state
  );

  modport slave (
    input  m_req, bus_done, bus_split, split_release,
    output m_grant, m_timeout, owner_id, bus_busy, arb_state
  );
endinterface

// File: rtl/bus_arbiter_rr.sv
// N-master bus arbiter: round-robin or fixed priority, ownership timeout and
// slave-initiated split parking with per-master release.
module bus_arbiter_rr #(
  parameter int unsigned N_MASTERS      = 2,
  parameter int unsigned PRIORITY_MODE  = 0,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned ID_W           = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  bus_arbiter_rr_if.slave bus
);

  localparam int unsigned CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned CNT_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic        TMO_EN   = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t               state;
  logic [N_MASTERS-1:0] grant_q;
  logic [N_MASTERS-1:0] timeout_q;
  logic [N_MASTERS-1:0] split_mask;
  logic [ID_W-1:0]      owner;
  logic [ID_W-1:0]      rr_ptr;
  logic [CNT_W-1:0]     hold_cnt;
  logic                 busy_q;

  logic [N_MASTERS-1:0] eligible;
  logic [N_MASTERS-1:0] win_onehot;
  logic [N_MASTERS-1:0] own_onehot;
  logic [N_MASTERS-1:0] mask_nxt;
  logic [ID_W-1:0]      winner;
  logic [ID_W-1:0]      idx;
  logic                 win_valid;
  logic                 in_busy;
  logic                 ev_split;
  logic                 ev_abandon;
  logic                 ev_timeout;
  logic                 busy_exit;

  assign eligible = bus.m_req & ~split_mask;

  // Winner search; iterating from the far end leaves the nearest candidate last.
  always_comb begin
    winner    = '0;
    idx       = '0;
    win_valid = 1'b0;
    if (PRIORITY_MODE != 0) begin
      for (int i = int'(N_MASTERS) - 1; i >= 0; i--) begin
        if (eligible[ID_W'(i)]) begin
          winner    = ID_W'(i);
          win_valid = 1'b1;
        end
      end
    end else begin
      for (int off = int'(N_MASTERS); off >= 1; off--) begin
        idx = ID_W'((int'(rr_ptr) + off) % int'(N_MASTERS));
        if (eligible[idx]) begin
          winner    = idx;
          win_valid = 1'b1;
        end
      end
    end
  end

  // BUSY exit events in priority order: done, split, abandon, timeout.
  always_comb begin
    win_onehot         = '0;
    win_onehot[winner] = 1'b1;
    own_onehot         = '0;
    own_onehot[owner]  = 1'b1;
    in_busy    = (state == ST_BUSY);
    ev_split   = in_busy && !bus.bus_done && bus.bus_split;
    ev_abandon = in_busy && !bus.bus_done && !bus.bus_split && !bus.m_req[owner];
    ev_timeout = in_busy && !bus.bus_done && !bus.bus_split && bus.m_req[owner] &&
                 TMO_EN && (hold_cnt == CNT_W'(CNT_LAST));
    busy_exit  = in_busy && (bus.bus_done || ev_split || ev_abandon || ev_timeout);
    mask_nxt   = (split_mask & ~bus.split_release) | (ev_split ? own_onehot : '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      grant_q    <= '0;
      timeout_q  <= '0;
      split_mask <= '0;
      owner      <= '0;
      rr_ptr     <= ID_W'(N_MASTERS - 1);
      hold_cnt   <= '0;
      busy_q     <= 1'b0;
    end else begin
      timeout_q  <= '0;
      split_mask <= mask_nxt;
      case (state)
        ST_IDLE: begin
          if (win_valid) begin
            state    <= ST_BUSY;
            grant_q  <= win_onehot;
            owner    <= winner;
            busy_q   <= 1'b1;
            hold_cnt <= '0;
            if (PRIORITY_MODE == 0) rr_ptr <= winner;
          end
        end
        ST_BUSY: begin
          hold_cnt <= hold_cnt + CNT_W'(1);
          if (busy_exit) begin
            state   <= ST_RELEASE;
            grant_q <= '0;
            busy_q  <= 1'b0;
            if (ev_timeout) timeout_q <= own_onehot;
          end
        end
        ST_RELEASE: state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  assign bus.m_grant   = grant_q;
  assign bus.m_timeout = timeout_q;
  assign bus.owner_id  = owner;
  assign bus.bus_busy  = busy_q;
  assign bus.arb_state = state;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Bench for bus_arbiter_rr: round-robin and fixed-priority instances on shared
// stimulus, checked every cycle against a per-instance ownership model.
module tb_bus_arbiter_rr;
  localparam int unsigned N  = 3;
  localparam int unsigned T  = 8;
  localparam int unsigned IW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0] req, rel;
  logic         done, split;

  bus_arbiter_rr_if #(.N_MASTERS(N), .ID_W(IW)) bif_rr ();
  bus_arbiter_rr_if #(.N_MASTERS(N), .ID_W(IW)) bif_fp ();

  assign bif_rr.m_req = req;  assign bif_rr.split_release = rel;
  assign bif_rr.bus_done = done;  assign bif_rr.bus_split = split;
  assign bif_fp.m_req = req;  assign bif_fp.split_release = rel;
  assign bif_fp.bus_done = done;  assign bif_fp.bus_split = split;

  bus_arbiter_rr #(.N_MASTERS(N), .PRIORITY_MODE(0), .TIMEOUT_CYCLES(T), .ID_W(IW))
    dut_rr (.clk(clk), .rst_n(rst_n), .bus(bif_rr.slave));
  bus_arbiter_rr #(.N_MASTERS(N), .PRIORITY_MODE(1), .TIMEOUT_CYCLES(T), .ID_W(IW))
    dut_fp (.clk(clk), .rst_n(rst_n), .bus(bif_fp.slave));

  int checks = 0;
  int errors = 0;

  // Ownership model: who holds the bus, for how many cycles, turnaround, parked masters.
  int           m_own [2];
  int           m_held[2];
  int           m_ptr [2];
  bit           m_busy[2];
  bit           m_turn[2];
  logic [N-1:0] m_mask[2];
  logic [N-1:0] m_tov [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_own[k] = 0; m_held[k] = 0; m_ptr[k] = int'(N) - 1;
      m_busy[k] = 0; m_turn[k] = 0; m_mask[k] = '0; m_tov[k] = '0;
    end
  endtask

  task automatic model_step(input int k);
    logic [N-1:0] old_mask, setb, elig;
    bit found;
    int w, c;
    old_mask = m_mask[k];
    setb     = '0;
    m_tov[k] = '0;
    if (m_busy[k]) begin
      if (done) begin
        m_busy[k] = 0; m_turn[k] = 1;
      end else if (split) begin
        setb[m_own[k]] = 1'b1; m_busy[k] = 0; m_turn[k] = 1;
      end else if (!req[m_own[k]]) begin
        m_busy[k] = 0; m_turn[k] = 1;
      end else if (m_held[k] == int'(T)) begin
        m_tov[k][m_own[k]] = 1'b1; m_busy[k] = 0; m_turn[k] = 1;
      end else begin
        m_held[k]++;
      end
    end else if (m_turn[k]) begin
      m_turn[k] = 0;
    end else begin
      elig  = req & ~old_mask;
      found = 0;
      w     = 0;
      for (int off = 0; off < int'(N); off++) begin
        c = (k == 0) ? (m_ptr[k] + 1 + off) % int'(N) : off;
        if (!found && elig[c]) begin found = 1; w = c; end
      end
      if (found) begin
        m_busy[k] = 1; m_own[k] = w; m_held[k] = 1;
        if (k == 0) m_ptr[k] = w;
      end
    end
    m_mask[k] = (old_mask & ~rel) | setb;
  endtask

  task automatic check_all();
    logic [N-1:0] g;
    logic [1:0]   st;
    for (int k = 0; k < 2; k++) begin
      g = '0;
      if (m_busy[k]) g[m_own[k]] = 1'b1;
      st = m_busy[k] ? 2'd1 : (m_turn[k] ? 2'd2 : 2'd0);
      if (k == 0) begin
        chk("rr grant",   32'(bif_rr.m_grant),   32'(g));
        chk("rr timeout", 32'(bif_rr.m_timeout), 32'(m_tov[k]));
        chk("rr owner",   32'(bif_rr.owner_id),  32'(m_own[k]));
        chk("rr busy",    32'(bif_rr.bus_busy),  32'(m_busy[k]));
        chk("rr state",   32'(bif_rr.arb_state), 32'(st));
      end else begin
        chk("fp grant",   32'(bif_fp.m_grant),   32'(g));
        chk("fp timeout", 32'(bif_fp.m_timeout), 32'(m_tov[k]));
        chk("fp owner",   32'(bif_fp.owner_id),  32'(m_own[k]));
        chk("fp busy",    32'(bif_fp.bus_busy),  32'(m_busy[k]));
        chk("fp state",   32'(bif_fp.arb_state), 32'(st));
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check_all();
  endtask

  // Advance until model instance k is in BUSY (optionally with a given owner/hold count).
  task automatic wait_busy(input string tag, input int k, input int who, input int held);
    bit found = 0;
    for (int n = 0; n < 80 && !found; n++) begin
      if (m_busy[k] && (who < 0 || m_own[k] == who) && (held < 0 || m_held[k] == held))
        found = 1;
      else
        step();
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  initial begin
    req = '0; rel = '0; done = 1'b0; split = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("reset grant", 32'(bif_rr.m_grant), 32'd0);
    rst_n = 1'b1;

    // Basic grant latency and release turnaround.
    step(); step();
    req = 3'b001;
    step();
    chk("first grant", 32'(bif_rr.m_grant), 32'b001);
    chk("first busy",  32'(bif_rr.bus_busy), 32'd1);
    step();
    done = 1'b1; req = 3'b000;
    step();
    done = 1'b0;
    chk("release state", 32'(bif_rr.arb_state), 32'd2);
    step();
    chk("idle state", 32'(bif_rr.arb_state), 32'd0);

    // Fairness: two requesters, done on every second BUSY cycle.
    req = 3'b011;
    for (int g = 0; g < 6; g++) begin
      wait_busy("fair wait", 0, -1, 2);
      done = 1'b1; step(); done = 1'b0;
      wait_busy("fair fp", 1, -1, -1);
      chk("fp fixed", 32'(bif_fp.m_grant), 32'b001);
    end

    // Timeout: master 1 alone, then master 0 joins and takes over after the abort.
    done = 1'b1; step(); done = 1'b0;
    req = 3'b010;
    repeat (14) step();
    req = 3'b011;
    repeat (26) step();

    // Split: park master 0, master 1 served, then unmask master 0.
    wait_busy("split wait", 0, 0, 2);
    split = 1'b1; step(); split = 1'b0;
    repeat (12) step();
    rel = 3'b001; step(); rel = 3'b000;
    repeat (6) begin
      wait_busy("after rel", 0, -1, 2);
      done = 1'b1; step(); done = 1'b0;
    end

    // Simultaneous done+split (no mask) and done on the timeout cycle (no pulse).
    wait_busy("dsplit wait", 1, 0, 2);
    done = 1'b1; split = 1'b1; step(); done = 1'b0; split = 1'b0;
    wait_busy("dsplit regrant", 1, -1, -1);
    chk("dsplit fp regrant", 32'(bif_fp.m_grant), 32'b001);
    wait_busy("dtmo wait", 0, -1, int'(T));
    done = 1'b1; step(); done = 1'b0;
    chk("dtmo pulse", 32'(bif_rr.m_timeout), 32'd0);

    // Reset while master 1 owns the round-robin instance.
    req = 3'b010;
    wait_busy("rst wait", 0, 1, -1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1 check_all();
    rst_n = 1'b1;
    req = 3'b011;
    step(); step();
    chk("post-reset owner", 32'(bif_rr.m_grant), 32'b001);

    // Randomised traffic.
    for (int n = 0; n < 600; n++) begin
      for (int b = 0; b < int'(N); b++) if ($urandom_range(7) == 0) req[b] = ~req[b];
      done  = ($urandom_range(4) == 0);
      split = ($urandom_range(11) == 0);
      for (int b = 0; b < int'(N); b++) rel[b] = ($urandom_range(5) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bus_arbiter_rr.md
Name: bus_arbiter_rr

Overview:
Parametrised N-master arbiter for the shared system bus. It generalises the fixed two-master bus (m1/m2) to N_MASTERS requesters. It grants exactly one master at a time using round-robin or fixed priority, and supports an ownership timeout and a slave-initiated split. It sits between the master interface FSMs and the bus mux/decoder; its grant vector drives the address/data/control mux select.

Parameters:
N_MASTERS, 2, number of requesting masters (2..8)
PRIORITY_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins)
TIMEOUT_CYCLES, 64, maximum cycles a master may hold the bus in BUSY; 0 disables the timeout
ID_W, $clog2(N_MASTERS), width of owner_id (minimum 1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
m_req  in  N_MASTERS  per-master bus request, held high until transaction complete
m_grant  out  N_MASTERS  registered one-hot grant; all zero when no owner
m_timeout  out  N_MASTERS  one-cycle pulse to the owner whose hold was aborted by timeout
bus_done  in  1  slave completion pulse for the current transfer
bus_split  in  1  slave split request: park current owner, free the bus
split_release  in  N_MASTERS  per-master unmask pulse issued by slave when split data is ready
owner_id  out  ID_W  binary index of current/last owner
bus_busy  out  1  high while in BUSY
arb_state  out  2  FSM state for debug (0 IDLE, 1 BUSY, 2 RELEASE)

Behaviour:
- Reset (async, rst_n low): m_grant=0, m_timeout=0, owner_id=0, bus_busy=0, arb_state=IDLE, split_mask=0, timeout counter=0, RR pointer=N_MASTERS-1 (so master 0 wins first).
- eligible = m_req & ~split_mask.
- IDLE: if eligible!=0, pick winner; next edge -> BUSY with m_grant[winner]=1, owner_id=winner, counter=0. Latency: req high in cycle n -> grant visible cycle n+1. eligible==0 -> stay IDLE, grant 0.
- Winner selection, RR: first set bit of eligible searching from pointer+1 modulo N_MASTERS (wrap-around). Pointer updates to winner on grant. Fixed: lowest set index; pointer unused.
- BUSY: counter increments each cycle. Exit conditions, evaluated by priority:
  1. bus_done: -> RELEASE.
  2. bus_split: set split_mask[owner] -> RELEASE.
  3. m_req[owner]==0 (master abandons): -> RELEASE.
  4. TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1: pulse m_timeout[owner] for one cycle (the cycle in RELEASE) -> RELEASE.
- Simultaneous events: bus_done with bus_split -> done wins, no mask set. Done on the timeout cycle -> no timeout pulse.
- RELEASE: m_grant=0, bus_busy=0 for exactly one turnaround cycle; owner_id holds. Next edge -> IDLE; re-arbitration happens in IDLE, so back-to-back ownership costs IDLE+RELEASE (2 idle-grant cycles minimum between owners).
- split_release[i] clears split_mask[i] at the next edge. If bus_split sets bit i in the same cycle that split_release[i] is high, the set wins.
- A masked master's m_req is ignored; it is not granted until released.
- At most one m_grant bit set at any time; grant never changes while in BUSY.
- m_req deasserting for a non-owner has no effect.
- N_MASTERS=1: always winner 0; split still masks it.

Test Plan:
- Reset then m_req=2'b01 at cycle 3 -> m_grant=01 at cycle 4, bus_busy=1, owner_id=0; bus_done at cycle 6 -> cycle 7 grant=00, arb_state=2; cycle 8 arb_state=0.
- RR fairness, N=2: m_req=11 held, bus_done every BUSY cycle 2 -> grants alternate 01,10,01,10; PRIORITY_MODE=1 same stimulus -> always 01.
- Timeout, TIMEOUT_CYCLES=8: grant master 1, no bus_done -> after 8 BUSY cycles m_timeout=10 for one cycle, grant drops, then master 0 (requesting) granted.
- Split: master 0 owns, bus_split pulse -> master 0 masked, master 1 granted despite m_req[0]=1; split_release=01 -> after master 1 done, master 0 regranted.
- Simultaneous: bus_done+bus_split same cycle -> split_mask stays 0; bus_done on timeout cycle -> m_timeout stays 0.
- Reset mid-BUSY (rst_n low 1 cycle while grant=10) -> immediately m_grant=0, state IDLE, split_mask=0; after release, master 0 wins first.
